// File: rtl/vga_pkg.sv
// Shared VGA display types: display modes, active-area constants and the
// per-pixel flag bundle carried alongside frame-buffer reads.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_GRAY    = 2'b00,
    MODE_BIN     = 2'b01,
    MODE_INV     = 2'b10,
    MODE_OVERLAY = 2'b11
  } disp_mode_t;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef struct packed {
    logic hSync;
    logic vSync;
    logic blankB;
    logic inImg;
  } pix_flags_t;

  localparam pix_flags_t FLAGS_IDLE = '{hSync: 1'b1, vSync: 1'b1, blankB: 1'b0, inImg: 1'b0};

  // Maps one grey sample to {r,g,b} for a pixel known to lie inside the image.
  function automatic logic [23:0] shadePixel(input disp_mode_t mode, input logic [7:0] p,
                                             input logic [7:0] thresh);
    logic [23:0] rgb;
    logic        hit;
    hit = (p >= thresh);
    case (mode)
      MODE_GRAY: rgb = {p, p, p};
      MODE_BIN:  rgb = hit ? 24'hFFFFFF : 24'h000000;
      MODE_INV:  rgb = {~p, ~p, ~p};
      default:   rgb = hit ? 24'h00FF00 : {1'b0, p[7:1], 1'b0, p[7:1], 1'b0, p[7:1]};
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register whose stages all clear to a chosen idle value,
// so delayed control signals come out of reset in their inactive state.
module sync_delay #(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= RESET_VAL;
    end else begin
      stages[0] <= d;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/vga_frame_reader.sv
// Turns the VGA controller's coordinate/sync stream into colour by reading an
// upscaled grey image from a double-buffered frame store.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int          IMG_W       = 160,
  parameter int          IMG_H       = 120,
  parameter int          SCALE_SHIFT = 2,
  parameter int          RD_LATENCY  = 1,
  parameter int          ADDR_W      = 16,
  parameter logic [7:0]  BORDER      = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              hSyncIn,
  input  logic              vSyncIn,
  input  logic              blankBIn,
  input  logic [1:0]        mode,
  input  logic [7:0]        thresh,
  output logic              rdEn,
  output logic [ADDR_W-1:0] rdAddr,
  input  logic [7:0]        rdData,
  input  logic              swapReq,
  output logic              swapAck,
  output logic              bufSel,
  output logic              hSync,
  output logic              vSync,
  output logic              blankB,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b
);

  localparam logic [10:0]       ACT_W      = 11'(IMG_W << SCALE_SHIFT);
  localparam logic [10:0]       ACT_H      = 11'(IMG_H << SCALE_SHIFT);
  localparam logic [ADDR_W-1:0] BUF_OFFSET = ADDR_W'(IMG_W * IMG_H);

  logic              atOrigin;
  logic              prevOrigin;
  logic              frameStart;
  logic              doSwap;
  logic              selNext;
  logic              inImg;
  logic [ADDR_W-1:0] rowBase;
  logic [ADDR_W-1:0] pixAddr;
  pix_flags_t        flagsIn;
  pix_flags_t        flagsDly;

  // A frame starts on the first cycle the controller reports (0,0), so a
  // held origin coordinate cannot trigger repeated swaps.
  assign atOrigin   = (x == 10'd0) && (y == 10'd0);
  assign frameStart = atOrigin && !prevOrigin;
  assign doSwap     = frameStart && swapReq;
  assign selNext    = bufSel ^ doSwap;

  assign inImg   = blankBIn && ({1'b0, x} < ACT_W) && ({1'b0, y} < ACT_H);
  assign rowBase = ADDR_W'(y >> SCALE_SHIFT) * ADDR_W'(IMG_W);
  assign pixAddr = (selNext ? BUF_OFFSET : '0) + rowBase + ADDR_W'(x >> SCALE_SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      prevOrigin <= 1'b0;
      bufSel     <= 1'b0;
      swapAck    <= 1'b0;
      rdEn       <= 1'b0;
      rdAddr     <= '0;
    end else begin
      prevOrigin <= atOrigin;
      bufSel     <= selNext;
      swapAck    <= doSwap;
      rdEn       <= inImg;
      if (inImg) rdAddr <= pixAddr;
    end
  end

  assign flagsIn = '{hSync: hSyncIn, vSync: vSyncIn, blankB: blankBIn, inImg: inImg};

  // Flags wait out the address register plus the read latency, then meet rdData.
  sync_delay #(
    .WIDTH     (4),
    .DEPTH     (RD_LATENCY + 1),
    .RESET_VAL (FLAGS_IDLE)
  ) flagDelay (
    .clk (clk),
    .rst (rst),
    .d   (flagsIn),
    .q   (flagsDly)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hSync     <= 1'b1;
      vSync     <= 1'b1;
      blankB    <= 1'b0;
      {r, g, b} <= 24'h000000;
    end else begin
      hSync  <= flagsDly.hSync;
      vSync  <= flagsDly.vSync;
      blankB <= flagsDly.blankB;
      if (!flagsDly.blankB)
        {r, g, b} <= 24'h000000;
      else if (!flagsDly.inImg)
        {r, g, b} <= {BORDER, BORDER, BORDER};
      else
        {r, g, b} <= shadePixel(disp_mode_t'(mode), rdData, thresh);
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Randomized bench for vga_frame_reader: a frame-store memory model feeds the
// DUT and a queue-based reference predicts every registered output.
module tb_vga_frame_reader;

  localparam int L       = 3;
  localparam int IMG_PIX = 160 * 120;

  typedef struct {
    logic hs;
    logic vs;
    logic blank;
    logic inImg;
    int   addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  x, y;
  logic        hSyncIn, vSyncIn, blankBIn;
  logic [1:0]  mode;
  logic [7:0]  thresh;
  logic        rdEn;
  logic [15:0] rdAddr;
  logic [7:0]  rdData;
  logic        swapReq;
  logic        swapAck, bufSel;
  logic        hSync, vSync, blankB;
  logic [7:0]  r, g, b;

  logic [7:0]  mem [0:2*IMG_PIX-1];

  int   checksRun = 0;
  int   checksPassed = 0;
  exp_t q[$];
  logic mBufSel, mPrevOrigin, haveExp;
  int   mLastAddr;
  logic eRdEn, eAck, eSel;
  int   eAddr;

  vga_frame_reader dut (
    .clk      (clk),
    .rst      (rst),
    .x        (x),
    .y        (y),
    .hSyncIn  (hSyncIn),
    .vSyncIn  (vSyncIn),
    .blankBIn (blankBIn),
    .mode     (mode),
    .thresh   (thresh),
    .rdEn     (rdEn),
    .rdAddr   (rdAddr),
    .rdData   (rdData),
    .swapReq  (swapReq),
    .swapAck  (swapAck),
    .bufSel   (bufSel),
    .hSync    (hSync),
    .vSync    (vSync),
    .blankB   (blankB),
    .r        (r),
    .g        (g),
    .b        (b)
  );

  always #5 clk = ~clk;

  // Frame store with a one-cycle registered read port.
  always @(posedge clk) rdData <= mem[int'(rdAddr) % (2*IMG_PIX)];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checksRun++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  function automatic logic [23:0] refColour(input exp_t e, input int md, input int th);
    int p;
    if (!e.blank) return 24'h000000;
    if (!e.inImg) return 24'h000000;
    p = int'(mem[e.addr]);
    case (md)
      0:       return {8'(p), 8'(p), 8'(p)};
      1:       return (p >= th) ? 24'hFFFFFF : 24'h000000;
      2:       return {8'(255-p), 8'(255-p), 8'(255-p)};
      default: return (p >= th) ? 24'h00FF00 : {8'(p/2), 8'(p/2), 8'(p/2)};
    endcase
  endfunction

  task automatic applyStimulus(input logic rstV, input int xV, input int yV,
                               input logic hsV, input logic vsV, input logic blV);
    logic origin, start, ack, inImg;
    int   addr;
    rst = rstV; x = 10'(xV); y = 10'(yV);
    hSyncIn = hsV; vSyncIn = vsV; blankBIn = blV;
    if (rstV) begin
      mBufSel = 1'b0; mPrevOrigin = 1'b0; mLastAddr = 0;
      eRdEn = 1'b0; eAddr = 0; eAck = 1'b0; eSel = 1'b0;
      q = {};
      for (int i = 0; i < L; i++) q.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 0});
    end else begin
      origin = (xV == 0) && (yV == 0);
      start  = origin && !mPrevOrigin;
      mPrevOrigin = origin;
      ack = start && swapReq;
      if (ack) mBufSel = !mBufSel;
      inImg = blV && (xV < 640) && (yV < 480);
      addr  = (mBufSel ? IMG_PIX : 0) + (yV / 4) * 160 + (xV / 4);
      if (inImg) mLastAddr = addr;
      eRdEn = inImg; eAddr = mLastAddr; eAck = ack; eSel = mBufSel;
      q.push_back('{hsV, vsV, blV, inImg, addr});
    end
    haveExp = 1'b1;
  endtask

  // One pixel clock: check what the last edge produced, move the writer, drive new inputs.
  task automatic runCycle(input logic rstV, input int xV, input int yV,
                          input logic hsV, input logic vsV, input logic blV);
    exp_t e;
    @(negedge clk);
    if (haveExp) begin
      checkOutput("rdEn",    32'(rdEn),    32'(eRdEn));
      checkOutput("rdAddr",  32'(rdAddr),  32'(eAddr));
      checkOutput("swapAck", 32'(swapAck), 32'(eAck));
      checkOutput("bufSel",  32'(bufSel),  32'(eSel));
    end
    if (q.size() == L) begin
      e = q.pop_front();
      checkOutput("hSync",  32'(hSync),  32'(e.hs));
      checkOutput("vSync",  32'(vSync),  32'(e.vs));
      checkOutput("blankB", 32'(blankB), 32'(e.blank));
      checkOutput("rgb",    32'({r, g, b}), 32'(refColour(e, int'(mode), int'(thresh))));
    end
    if (swapAck) swapReq = 1'b0;
    else if (!swapReq && $urandom_range(0, 7) == 0) swapReq = 1'b1;
    applyStimulus(rstV, xV, yV, hsV, vsV, blV);
  endtask

  initial begin
    int xr, yr;
    logic bl;
    haveExp = 1'b0;
    swapReq = 1'b0;
    mode = 2'b00;
    thresh = 8'h40;
    for (int i = 0; i < 2*IMG_PIX; i++) mem[i] = 8'($urandom);
    mem[321] = 8'h80;
    mem[322] = 8'h3F;
    mem[323] = 8'h40;
    mem[324] = 8'h20;

    applyStimulus(1'b1, 0, 0, 1'b1, 1'b1, 1'b0);
    runCycle(1'b0, 290, 10, 1'b1, 1'b1, 1'b1);
    runCycle(1'b0, 299, 10, 1'b1, 1'b1, 1'b1);
    runCycle(1'b1, 300, 10, 1'b1, 1'b1, 1'b1);
    runCycle(1'b0, 5, 9, 1'b1, 1'b1, 1'b1);
    runCycle(1'b0, 5, 9, 1'b1, 1'b1, 1'b1);
    mode = 2'b01;
    runCycle(1'b0, 8, 9, 1'b1, 1'b1, 1'b1);
    runCycle(1'b0, 12, 9, 1'b1, 1'b1, 1'b1);
    runCycle(1'b0, 12, 9, 1'b1, 1'b1, 1'b1);
    mode = 2'b11;
    runCycle(1'b0, 16, 9, 1'b1, 1'b1, 1'b1);
    runCycle(1'b0, 640, 9, 1'b0, 1'b1, 1'b0);
    runCycle(1'b0, 100, 480, 1'b1, 1'b0, 1'b0);
    runCycle(1'b0, 700, 20, 1'b1, 1'b1, 1'b1);
    runCycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b1);
    mode = 2'b00;
    runCycle(1'b0, 1, 0, 1'b1, 1'b1, 1'b1);

    for (int n = 0; n < 4000; n++) begin
      xr = $urandom_range(0, 799);
      yr = $urandom_range(0, 524);
      if ($urandom_range(0, 15) == 0) begin xr = 0; yr = 0; end
      bl = (xr < 640) && (yr < 480);
      if ($urandom_range(0, 7) == 0) bl = 1'($urandom);
      if ($urandom_range(0, 31) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 31) == 0) thresh = 8'($urandom);
      runCycle(($urandom_range(0, 499) == 0), xr, yr, 1'($urandom), 1'($urandom), bl);
    end
    for (int n = 0; n < L + 1; n++) runCycle(1'b0, 700, 500, 1'b1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end

endmodule
